// File: rtl/hls_contrast_strmul_pipe.sv
// Elastic multiply pipeline: full-width signed/unsigned product, optional rounded
// right shift and saturation, with valid/ready handshakes on both sides.
module hls_contrast_strmul_pipe #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 22,
  parameter int P_WIDTH   = 29,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int SATURATE  = 1
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] dout,
  output logic               sat
);

  localparam int PROD_W   = A_WIDTH + B_WIDTH;
  localparam int EXT_W    = PROD_W + 1;
  localparam int HI_W     = EXT_W - P_WIDTH + 1;
  localparam int MID_N    = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int LAST_SRC = (NUM_STAGE > 1) ? NUM_STAGE - 2 : 0;
  localparam int RND_POS  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EXT_W-1:0] RND =
    (SHIFT > 0) ? ({{(EXT_W-1){1'b0}}, 1'b1} << RND_POS) : '0;

  logic [NUM_STAGE-1:0] vld_q, vld_d, load;
  logic [PROD_W-1:0]    prod_q [MID_N];
  logic [PROD_W-1:0]    prod_d [MID_N];
  logic [MID_N-1:0]     mode_q, mode_d;
  logic [P_WIDTH-1:0]   dout_q, dout_d;
  logic                 sat_q, sat_d;

  logic [PROD_W-1:0]    op_a, op_b, prod_in;
  logic [PROD_W-1:0]    last_prod;
  logic                 last_mode, last_vld;
  logic signed [EXT_W-1:0] ext_v, rnd_v, shf_v;
  logic [HI_W-1:0]      hi_v;
  logic [P_WIDTH-1:0]   res_dout;
  logic                 res_sat;

  // Extending both operands to the product width makes the low bits of a plain
  // multiply equal the exact signed or unsigned product.
  always_comb begin
    op_a    = {{B_WIDTH{din0[A_WIDTH-1] & mode}}, din0};
    op_b    = {{A_WIDTH{din1[B_WIDTH-1] & mode}}, din1};
    prod_in = op_a * op_b;
  end

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    logic chain;
    chain = out_ready;
    load  = '0;
    for (int s = NUM_STAGE - 1; s >= 0; s--) begin
      load[s] = ~vld_q[s] | chain;
      chain   = ~vld_q[s] | chain;
    end
  end

  assign in_ready = load[0] & ~ap_rst;

  always_comb begin
    if (NUM_STAGE > 1) begin
      last_vld  = vld_q[LAST_SRC];
      last_prod = prod_q[MID_N-1];
      last_mode = mode_q[MID_N-1];
    end else begin
      last_vld  = in_valid & in_ready;
      last_prod = prod_in;
      last_mode = mode;
    end
  end

  // Rounding uses one guard bit above the product so the add never wraps.
  always_comb begin
    ext_v    = last_mode ? $signed({last_prod[PROD_W-1], last_prod})
                         : $signed({1'b0, last_prod});
    rnd_v    = ext_v + $signed(RND);
    shf_v    = rnd_v >>> SHIFT;
    hi_v     = shf_v[EXT_W-1:P_WIDTH-1];
    res_dout = shf_v[P_WIDTH-1:0];
    res_sat  = 1'b0;
    if (SATURATE != 0) begin
      if (!last_mode) begin
        if (hi_v[HI_W-1:1] != '0) begin
          res_dout = '1;
          res_sat  = 1'b1;
        end
      end else if (hi_v != '0 && hi_v != '1) begin
        res_dout = hi_v[HI_W-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                : {1'b0, {(P_WIDTH-1){1'b1}}};
        res_sat  = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = load[0] ? (in_valid & in_ready) : vld_q[0];
    for (int s = 1; s < NUM_STAGE; s++) begin
      vld_d[s] = load[s] ? vld_q[s-1] : vld_q[s];
    end
    prod_d = prod_q;
    mode_d = mode_q;
    if (NUM_STAGE > 1) begin
      if (load[0] && in_valid && in_ready) begin
        prod_d[0] = prod_in;
        mode_d[0] = mode;
      end
      for (int s = 1; s < NUM_STAGE - 1; s++) begin
        if (load[s] && vld_q[s-1]) begin
          prod_d[s] = prod_q[s-1];
          mode_d[s] = mode_q[s-1];
        end
      end
    end
    dout_d = dout_q;
    sat_d  = sat_q;
    if (load[NUM_STAGE-1] && last_vld) begin
      dout_d = res_dout;
      sat_d  = res_sat;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
      for (int s = 0; s < MID_N; s++) prod_q[s] <= '0;
    end else begin
      vld_q  <= vld_d;
      prod_q <= prod_d;
      mode_q <= mode_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_hls_contrast_strmul_pipe.sv
// Scoreboard bench for hls_contrast_strmul_pipe: four parameterisations share one
// input stream; each has its own expected-result queue fed from an arithmetic model.
module tb_hls_contrast_strmul_pipe;

  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  din0 = '0;
  logic [21:0] din1 = '0;
  logic        mode = 1'b0;

  logic        ir_def, ir_tr, ir_sh, ir_s1;
  logic        ov_def, ov_tr, ov_sh, ov_s1;
  logic        sat_def, sat_tr, sat_sh, sat_s1;
  logic [28:0] dout_def, dout_tr, dout_sh;
  logic [11:0] dout_s1;

  localparam int PN   [4] = '{3, 3, 3, 1};
  localparam int PS   [4] = '{0, 0, 4, 3};
  localparam int PP   [4] = '{29, 29, 29, 12};
  localparam int PSAT [4] = '{1, 0, 1, 1};

  logic   ir_w [4];
  logic   ov_w [4];
  logic   sat_w [4];
  longint dout_w [4];
  longint exp_q [4][$];
  int     pops [4];
  logic   held_v [4];
  longint held_d [4];
  logic   held_s [4];

  int     n_compared = 0;
  int     n_mismatched = 0;
  longint cap_d [3];
  logic   cap_s [3];

  always #5 clk = ~clk;

  hls_contrast_strmul_pipe u_def (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir_def),
    .din0(din0), .din1(din1), .mode(mode), .out_valid(ov_def),
    .out_ready(out_ready), .dout(dout_def), .sat(sat_def));

  hls_contrast_strmul_pipe #(.SATURATE(0)) u_tr (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir_tr),
    .din0(din0), .din1(din1), .mode(mode), .out_valid(ov_tr),
    .out_ready(out_ready), .dout(dout_tr), .sat(sat_tr));

  hls_contrast_strmul_pipe #(.SHIFT(4)) u_sh (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir_sh),
    .din0(din0), .din1(din1), .mode(mode), .out_valid(ov_sh),
    .out_ready(out_ready), .dout(dout_sh), .sat(sat_sh));

  hls_contrast_strmul_pipe #(.NUM_STAGE(1), .P_WIDTH(12), .SHIFT(3)) u_s1 (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir_s1),
    .din0(din0), .din1(din1), .mode(mode), .out_valid(ov_s1),
    .out_ready(out_ready), .dout(dout_s1), .sat(sat_s1));

  always_comb begin
    ir_w[0] = ir_def;  ir_w[1] = ir_tr;  ir_w[2] = ir_sh;  ir_w[3] = ir_s1;
    ov_w[0] = ov_def;  ov_w[1] = ov_tr;  ov_w[2] = ov_sh;  ov_w[3] = ov_s1;
    sat_w[0] = sat_def; sat_w[1] = sat_tr; sat_w[2] = sat_sh; sat_w[3] = sat_s1;
    dout_w[0] = longint'(dout_def);
    dout_w[1] = longint'(dout_tr);
    dout_w[2] = longint'(dout_sh);
    dout_w[3] = longint'(dout_s1);
  end

  // Result = round(a*b / 2^shift), then clamp or wrap into pw bits; packed as {sat, dout}.
  function automatic longint ref_model(input longint a_raw, input longint b_raw, input logic md,
                                       input int shift, input int pw, input int sat_en);
    longint a, b, v, hi, lo, mask;
    logic s;
    a = a_raw;
    b = b_raw;
    if (md) begin
      if (a >= 128) a = a - 256;
      if (b >= (longint'(1) << 21)) b = b - (longint'(1) << 22);
    end
    v = a * b;
    if (shift > 0) v = (v + (longint'(1) << (shift - 1))) >>> shift;
    s = 1'b0;
    if (sat_en != 0) begin
      if (!md) begin
        hi = (longint'(1) << pw) - 1;
        if (v > hi) begin v = hi; s = 1'b1; end
      end else begin
        hi = (longint'(1) << (pw - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin v = hi; s = 1'b1; end
        if (v < lo) begin v = lo; s = 1'b1; end
      end
    end
    mask = (longint'(1) << pw) - 1;
    return (longint'(s) << 32) | (v & mask);
  endfunction

  task automatic check_output(input string nm, input longint act, input longint exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: handshakes are settled 1 time unit after the negedge and hold to the next posedge.
  always begin
    longint e;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ap_rst) begin
        exp_q[i].delete();
        held_v[i] = 1'b0;
      end else begin
        check_output($sformatf("u%0d in_ready", i), longint'(ir_w[i]),
                     longint'(!(exp_q[i].size() == PN[i] && !out_ready)));
        if (held_v[i]) begin
          check_output($sformatf("u%0d hold out_valid", i), longint'(ov_w[i]), 1);
          check_output($sformatf("u%0d hold dout", i), dout_w[i], held_d[i]);
          check_output($sformatf("u%0d hold sat", i), longint'(sat_w[i]), longint'(held_s[i]));
        end
        held_v[i] = ov_w[i] && !out_ready;
        held_d[i] = dout_w[i];
        held_s[i] = sat_w[i];
        if (ov_w[i] && out_ready) begin
          if (exp_q[i].size() == 0) begin
            check_output($sformatf("u%0d unexpected result", i), 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            check_output($sformatf("u%0d dout", i), dout_w[i], e & 64'hFFFF_FFFF);
            check_output($sformatf("u%0d sat", i), longint'(sat_w[i]), (e >> 32) & 1);
          end
          pops[i]++;
        end
        if (in_valid && ir_w[i])
          exp_q[i].push_back(ref_model(longint'(din0), longint'(din1), mode,
                                       PS[i], PP[i], PSAT[i]));
      end
    end
  end

  // One isolated transfer with out_ready high; checks the three-cycle latency on u_def.
  task automatic apply_stimulus(input logic [7:0] a, input logic [21:0] b, input logic md);
    logic early;
    @(negedge clk);
    din0 = a; din1 = b; mode = md; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 early = ov_def;
    @(negedge clk);
    #2 early = early | ov_def;
    check_output("latency early out_valid", longint'(early), 0);
    @(negedge clk);
    #2 check_output("latency out_valid", longint'(ov_def), 1);
    cap_d[0] = dout_w[0]; cap_d[1] = dout_w[1]; cap_d[2] = dout_w[2];
    cap_s[0] = sat_w[0];  cap_s[1] = sat_w[1];  cap_s[2] = sat_w[2];
  endtask

  function automatic logic [7:0] pick_a();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [21:0] pick_b();
    case ($urandom_range(0, 7))
      0: return 22'h200000;
      1: return 22'h3FFFFF;
      2: return 22'h1FFFFF;
      default: return 22'($urandom);
    endcase
  endfunction

  // Issues n transfers (as seen by u_def) with random gaps and random backpressure.
  task automatic run_stream(input int n);
    int   issued = 0;
    int   cyc = 0;
    logic need_new = 1'b1;
    while (issued < n && cyc < n * 20 + 100) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom);
      if (need_new) begin
        in_valid = ($urandom_range(0, 3) != 0);
        din0 = pick_a(); din1 = pick_b(); mode = 1'($urandom);
      end
      #1;
      need_new = !in_valid || ir_def;
      if (in_valid && ir_def) issued++;
    end
    check_output("stream issued count", issued, n);
  endtask

  task automatic drain();
    int cyc = 0;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    for (int i = 0; i < 4; i++)
      check_output($sformatf("u%0d pending after drain", i), exp_q[i].size(), 0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 4; i++) begin pops[i] = 0; held_v[i] = 1'b0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("u%0d reset out_valid", i), longint'(ov_w[i]), 0);
      check_output($sformatf("u%0d reset dout", i), dout_w[i], 0);
      check_output($sformatf("u%0d reset sat", i), longint'(sat_w[i]), 0);
      check_output($sformatf("u%0d reset in_ready", i), longint'(ir_w[i]), 0);
    end
    ap_rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)
      check_output($sformatf("u%0d in_ready after reset", i), longint'(ir_w[i]), 1);

    apply_stimulus(8'd200, 22'd1000, 1'b0);
    check_output("200x1000 dout", cap_d[0], 200000);
    check_output("200x1000 sat", longint'(cap_s[0]), 0);
    apply_stimulus(8'd255, 22'd4194303, 1'b0);
    check_output("unsigned max dout", cap_d[0], 536870911);
    check_output("unsigned max sat", longint'(cap_s[0]), 1);
    check_output("unsigned max trunc dout", cap_d[1], 532676353);
    check_output("unsigned max trunc sat", longint'(cap_s[1]), 0);
    apply_stimulus(8'hFF, 22'd5, 1'b1);
    check_output("-1x5 dout", cap_d[0], 29'h1FFFFFFB);
    check_output("-1x5 sat", longint'(cap_s[0]), 0);
    apply_stimulus(8'd3, 22'd6, 1'b0);
    check_output("shift 3x6", cap_d[2], 1);
    apply_stimulus(8'd8, 22'd3, 1'b0);
    check_output("shift 8x3", cap_d[2], 2);
    apply_stimulus(8'hF8, 22'd3, 1'b1);
    check_output("shift -8x3", cap_d[2], 29'h1FFFFFFF);
    apply_stimulus(8'h80, 22'h200000, 1'b1);
    check_output("signed max dout", cap_d[0], 268435455);
    check_output("signed max sat", longint'(cap_s[0]), 1);
    check_output("signed max trunc dout", cap_d[1], 268435456);
    check_output("signed max shift dout", cap_d[2], 16777216);
    drain();

    base = pops[0];
    run_stream(10);
    drain();
    check_output("ten results", pops[0] - base, 10);

    run_stream(300);
    drain();

    // Fill the pipe under backpressure, then pulse reset with three in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din0 = pick_a(); din1 = pick_b(); mode = 1'($urandom); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    ap_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("u%0d mid reset out_valid", i), longint'(ov_w[i]), 0);
      check_output($sformatf("u%0d mid reset dout", i), dout_w[i], 0);
      check_output($sformatf("u%0d mid reset in_ready", i), longint'(ir_w[i]), 0);
    end
    ap_rst = 1'b0;
    out_ready = 1'b1;
    base = pops[0];
    repeat (10) @(negedge clk);
    check_output("no stale results", pops[0] - base, 0);

    run_stream(40);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hls_contrast_strmul_pipe.md
HLS_CONTRAST_STRMUL_PIPE -- requirements
Module: hls_contrast_strmul_pipe

Interface
REQ-001 Parameter A_WIDTH, default 8: width of operand din0.
REQ-002 Parameter B_WIDTH, default 22: width of operand din1.
REQ-003 Parameter P_WIDTH, default 29: width of result dout; legal range is 2 to A_WIDTH+B_WIDTH.
REQ-004 Parameter NUM_STAGE, default 3: pipeline depth in register stages; legal range is 1 to 4.
REQ-005 Parameter SHIFT, default 0: arithmetic right shift applied to the full product; legal range is 0 to A_WIDTH+B_WIDTH-1.
REQ-006 Parameter SATURATE, default 1: 1 clamps out-of-range results, 0 truncates to the low P_WIDTH bits.
REQ-007 Port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 Port in_valid, input, 1 bit: an operand pair is presented.
REQ-010 Port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-011 Port din0, input, A_WIDTH bits: multiplicand.
REQ-012 Port din1, input, B_WIDTH bits: multiplier.
REQ-013 Port mode, input, 1 bit: 0 treats both operands as unsigned, 1 treats both as two's-complement; sampled with the operands.
REQ-014 Port out_valid, output, 1 bit: dout and sat are valid.
REQ-015 Port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-016 Port dout, output, P_WIDTH bits: the result.
REQ-017 Port sat, output, 1 bit: the result was clamped (always 0 when SATURATE=0).

Function
REQ-018 A transfer occurs on any edge where both valid and ready are high; this rule applies to the input side and the output side alike.
REQ-019 The pipeline is NUM_STAGE register stages, each holding a valid bit and its data; each transaction carries its own mode through the pipe.
REQ-020 Stage k loads from stage k-1 whenever stage k is empty or stage k advances this cycle; partially filled pipes therefore collapse bubbles.
REQ-021 The last stage advances when out_ready is high or the last stage is empty.
REQ-022 in_ready is combinational: high when stage 1 is empty or stage 1 advances this cycle; it does not depend on in_valid.
REQ-023 With out_ready held high, latency from input transfer to out_valid is exactly NUM_STAGE cycles, and throughput is one result per cycle.
REQ-024 The product is computed full-width (A_WIDTH+B_WIDTH bits), signed or unsigned per mode, with no intermediate truncation.
REQ-025 When SHIFT>0, the block adds 2^(SHIFT-1) before the arithmetic shift (round half toward +infinity); the addition uses one guard bit so it cannot wrap.
REQ-026 SATURATE=1, mode 0: a shifted value above 2^P_WIDTH-1 yields dout=2^P_WIDTH-1 and sat=1.
REQ-027 SATURATE=1, mode 1: a value outside [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1] clamps to the nearer bound and yields sat=1.
REQ-028 SATURATE=0: dout is the low P_WIDTH bits of the shifted value and sat=0.
REQ-029 While out_valid is high and out_ready is low, dout, sat and out_valid hold stable and no in-flight data is lost or duplicated.
REQ-030 Simultaneous input and output transfers on a full pipe are legal and preserve order.

Reset
REQ-031 While ap_rst is high at an edge, every stage valid bit clears; out_valid=0, dout=0, sat=0.
REQ-032 During reset, in_ready=0; after reset deasserts, the pipe is empty and in_ready=1.
REQ-033 Asserting reset mid-operation discards all in-flight transactions, and no result from them ever appears at the output.

Verification
REQ-034 Defaults, mode 0, out_ready=1: din0=200, din1=1000 -> dout=200000, sat=0, out_valid high exactly 3 cycles after the transfer.
REQ-035 Defaults, mode 0: din0=255, din1=4194303 (product 1069547265) -> dout=536870911, sat=1; with SATURATE=0 -> dout=532676353, sat=0.
REQ-036 Defaults, mode 1: din0=0xFF (-1), din1=5 -> dout=0x1FFFFFFB (-5), sat=0.
REQ-037 SHIFT=4, mode 0: 3x6 -> 1; 8x3 -> 2. Mode 1: din0=-8, din1=3 -> -1 (-1.5 rounds to -1).
REQ-038 Backpressure: stream 10 consecutive pairs with out_ready toggling randomly -> exactly 10 results, in order, each held stable while stalled; in_ready low only when the pipe is full and stalled.
REQ-039 Reset mid-stream: with 3 transactions in flight, pulse ap_rst for 1 cycle -> out_valid=0 the next cycle and no stale result emerges afterward.
